can_tx_arbiter: RTL and testbench
=================================

# can_tx_arbiter

Round-robin transmit arbiter that shares the single 32-bit `tx_valid`/`tx_ready`/`tx_data` transmit port of one `can_top` controller among `N_CH` local requesters.

- Each accepted word is held in a capture register, presented to `can_top`, and followed by an optional minimum inter-frame gap.
- The block sits between application-side producers (periodic senders, command sources) and `can_top`, replacing ad-hoc single-producer drive of `tx_valid`.

## Interface
Parameters:
- `N_CH`, default 4: number of requester channels (2..16).
- `GAP_CYCLES`, default 1000: minimum clocks from a `can_top` acceptance to the next grant (1..65535); only used when the gap feature is compiled in.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `N_CH`: per-channel word valid.
- `req_ready` out `N_CH`: per-channel accept; one-hot or zero.
- `req_data` in `N_CH*32`: channel i occupies bits `[32*i+31:32*i]`.
- `tx_valid` out 1: to `can_top.tx_valid`.
- `tx_ready` in 1: from `can_top.tx_ready`.
- `tx_data` out 32: to `can_top.tx_data`.
- `grant_ch` out `CH_W` (`$clog2(N_CH)`): channel of the word in flight / last granted.
- `busy` out 1: high in any state other than IDLE.

## Operation
States: IDLE, SEND, GAP (GAP exists only with the gap feature).

IDLE:
- Winner is the first channel with `req_valid=1`, searching upward from `(last_grant+1) mod N_CH` with wrap.
- `req_ready[winner]` is driven combinationally high in the same cycle. The handshake completes that cycle.
- At the edge, capture `req_data` into `tx_data_q`, set `last_grant` and `grant_ch` to the winner, and go to SEND.
- With no valid requester, stay in IDLE with all `req_ready=0`.

SEND:
- `tx_valid=1` and `tx_data=tx_data_q`, held stable until `tx_ready`.
- On `tx_valid & tx_ready`:
  - gap feature in: load `gap_cnt=GAP_CYCLES-1` and go to GAP, or go to IDLE if `GAP_CYCLES=1`;
  - gap feature out: go to IDLE.
- `req_ready` stays all-zero in SEND.

GAP:
- `gap_cnt` decrements each cycle; at 0, go to IDLE.
- No grants and `tx_valid=0` during GAP.

Other rules:
- `req_valid` deasserted by a requester before it is granted is not an error. The requester is simply skipped.
- Once granted, a word is never dropped. Only `rst` discards it.
- Fairness: with all channels continuously valid, grant order is 0,1,2,…,N_CH-1,0,…

## Timing
Reset values: state=IDLE, `last_grant=N_CH-1` (so channel 0 wins first), `grant_ch=0`, `tx_valid=0`, `tx_data=0`, `req_ready=0`, `busy=0`, `gap_cnt=0`.

Latency and throughput:
- Grant cycle t; `tx_valid` high at t+1.
- If `tx_ready` is already high at t+1, the next grant is possible at t+2 (gap out) or t+1+GAP_CYCLES (gap in).
- Sustained rate: one word per 2 cycles (gap out) or per GAP_CYCLES+1 cycles (gap in).

Boundary conditions:
- `rst` asserted in SEND or GAP aborts the word and the gap; outputs return to reset values the next cycle.
- `tx_ready` high while in IDLE or GAP is ignored.
- A single requester that is always valid is re-granted every round.
- `last_grant` wraps from N_CH-1 to 0.

Handshake rules:
- `req_ready` may depend on `req_valid`. `tx_valid` never depends on `tx_ready`.

## Configuration
- `CAN_TX_ARB_GAP_EN` defined: the GAP state, `gap_cnt` (16 bits) and `GAP_CYCLES` are active. This enforces a minimum spacing between words to `can_top`, which limits bus load per node.
- Not defined: no GAP state and no counter. SEND goes directly to IDLE on acceptance, and `GAP_CYCLES` is ignored.

## Structure
- Package `can_arb_pkg`:
  - state enum `arb_state_t` (IDLE, SEND, GAP);
  - `localparam` data width 32;
  - function `rr_pick(valid, last)` returning the winner index and a found flag.
- One sub-module `can_rr_picker`: combinational rotate, priority-encode, un-rotate over `N_CH`. It outputs `winner` and `any`, and is instantiated once.
- The top level holds the FSM, the capture register, `last_grant` and the gap counter.

## Test plan
- Reset, then `req_valid=4'b0000` for 20 cycles → `busy=0`, `tx_valid=0`, `req_ready=0`.
- Gap feature out, `N_CH=4`, all valid, `tx_ready=1`, channel i data = `32'hA0+i` → `tx_data` sequence A0,A1,A2,A3,A0 with one word every 2 cycles.
- Gap feature in, `GAP_CYCLES=5`, channel 2 alone valid, `tx_ready=1` → `req_ready[2]` pulses every 6 cycles and `grant_ch=2`.
- Channel 1 granted with data `32'hDEADBEEF`, `tx_ready` held low 10 cycles → `tx_valid` and `tx_data` stable for 10 cycles; accepted on cycle 11; no other `req_ready` during the stall.
- `rst` asserted mid-SEND, then channel 3 valid → the held word is never emitted, and the first grant after reset goes to channel 3 (channels 0–2 idle).
- `last_grant=3`, then channels 0 and 3 both valid → channel 0 wins, then channel 3.

Source files
------------

// File: rtl/can_arb_pkg.sv
// Shared types and helpers for the CAN transmit arbiter.
package can_arb_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned MaxCh = 16;
    localparam int unsigned GapW  = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StGap  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [3:0] idx;
        logic       found;
    } rr_pick_t;

    // Reference round-robin search over up to MaxCh channels. Unused channels
    // must be zero, so wrapping at MaxCh behaves like wrapping at the real count.
    function automatic rr_pick_t rr_pick(input logic [MaxCh-1:0] valid,
                                         input logic [3:0]       last);
        rr_pick_t   res;
        logic [3:0] idx;
        res = '0;
        for (int unsigned i = 1; i <= MaxCh; i++) begin
            idx = last + 4'(i);
            if (!res.found && valid[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/can_rr_picker.sv
// Combinational round-robin picker: rotate, priority-encode, un-rotate.
module can_rr_picker #(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] valid,
    input  logic [CH_W-1:0] last,
    output logic [CH_W-1:0] winner,
    output logic            any
);

    logic [2*N_CH-1:0] valid_dbl;
    logic [N_CH-1:0]   rot;
    int unsigned       start_idx;
    int unsigned       off_idx;
    int unsigned       sum_idx;

    always_comb begin
        start_idx = (32'(last) + 32'd1 >= N_CH) ? 32'd0 : 32'(last) + 32'd1;
        // Rotate so the search start lands at bit 0.
        valid_dbl = {valid, valid};
        rot       = N_CH'(valid_dbl >> start_idx);
        any       = 1'b0;
        off_idx   = 32'd0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!any && rot[i]) begin
                any     = 1'b1;
                off_idx = i;
            end
        end
        sum_idx = start_idx + off_idx;
        if (sum_idx >= N_CH) begin
            sum_idx = sum_idx - N_CH;
        end
        winner = CH_W'(sum_idx);
    end

endmodule

// File: rtl/can_tx_arbiter.sv
// Round-robin arbiter sharing one can_top transmit port among N_CH requesters.
// Define CAN_TX_ARB_GAP_EN to enforce a GAP_CYCLES minimum spacing between words.
module can_tx_arbiter
    import can_arb_pkg::*;
#(
    parameter  int unsigned N_CH       = 4,
    parameter  int unsigned GAP_CYCLES = 1000,
    localparam int unsigned CH_W       = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       req_valid,
    output logic [N_CH-1:0]       req_ready,
    input  logic [N_CH*DataW-1:0] req_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DataW-1:0]      tx_data,
    output logic [CH_W-1:0]       grant_ch,
    output logic                  busy
);

    arb_state_t       state_q, state_d;
    logic [CH_W-1:0]  last_grant_q, last_grant_d;
    logic [CH_W-1:0]  grant_ch_q, grant_ch_d;
    logic [DataW-1:0] tx_data_q, tx_data_d;
    logic [CH_W-1:0]  pick_winner;
    logic             pick_any;

`ifdef CAN_TX_ARB_GAP_EN
    localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 1);
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
`else
    logic unused_gap_cycles;
    assign unused_gap_cycles = ^GAP_CYCLES;
`endif

    can_rr_picker #(
        .N_CH (N_CH)
    ) u_picker (
        .valid  (req_valid),
        .last   (last_grant_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_ch_d   = grant_ch_q;
        tx_data_d    = tx_data_q;
        req_ready    = '0;
`ifdef CAN_TX_ARB_GAP_EN
        gap_cnt_d    = gap_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        if (pick_winner == CH_W'(i)) begin
                            req_ready[i] = 1'b1;
                            tx_data_d    = req_data[DataW*i +: DataW];
                        end
                    end
                    last_grant_d = pick_winner;
                    grant_ch_d   = pick_winner;
                    state_d      = StSend;
                end
            end
            StSend: begin
                if (tx_ready) begin
`ifdef CAN_TX_ARB_GAP_EN
                    if (GAP_CYCLES <= 1) begin
                        state_d = StIdle;
                    end else begin
                        gap_cnt_d = GapLoad;
                        state_d   = StGap;
                    end
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef CAN_TX_ARB_GAP_EN
            StGap: begin
                // Leave as the count reaches zero so acceptance-to-grant is GAP_CYCLES.
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q <= 1) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= CH_W'(N_CH - 1);
            grant_ch_q   <= '0;
            tx_data_q    <= '0;
`ifdef CAN_TX_ARB_GAP_EN
            gap_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_ch_q   <= grant_ch_d;
            tx_data_q    <= tx_data_d;
`ifdef CAN_TX_ARB_GAP_EN
            gap_cnt_q    <= gap_cnt_d;
`endif
        end
    end

    assign tx_valid = (state_q == StSend);
    assign tx_data  = tx_data_q;
    assign grant_ch = grant_ch_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Directed self-checking bench for can_tx_arbiter (N_CH=4, GAP_CYCLES=5).
module tb_can_tx_arbiter;

    localparam int unsigned NCh = 4;
    localparam int unsigned Gap = 5;
`ifdef CAN_TX_ARB_GAP_EN
    localparam int unsigned Period = Gap + 1;
`else
    localparam int unsigned Period = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NCh-1:0]   req_valid;
    logic [NCh-1:0]   req_ready;
    logic [NCh*32-1:0] req_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [31:0]      tx_data;
    logic [1:0]       grant_ch;
    logic             busy;
    logic [31:0]      ch_data [NCh];

    int n_checks = 0;
    int n_err    = 0;

    assign req_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    always #5 clk = ~clk;

    can_tx_arbiter #(
        .N_CH       (NCh),
        .GAP_CYCLES (Gap)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .grant_ch  (grant_ch),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]  mask;
        int unsigned ch;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Called at a negedge in IDLE with tx_ready=1.
    task automatic grant_one(input string tag, input logic [3:0] mask, input int unsigned ch);
        logic [31:0] exp_rdy;
        exp_rdy   = 32'd1 << ch;
        req_valid = mask;
        #1;
        check({tag, "_ready"}, 32'(req_ready), exp_rdy);
        @(negedge clk);
        req_valid = '0;
        check({tag, "_grant"}, 32'(grant_ch), ch);
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_data"}, tx_data, ch_data[ch]);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        tx_ready  = 1'b1;
        for (int i = 0; i < NCh; i++) ch_data[i] = 32'hA0 + 32'(i);

        vecs[0]  = '{4'b1111, 0};
        vecs[1]  = '{4'b1111, 1};
        vecs[2]  = '{4'b1111, 2};
        vecs[3]  = '{4'b1111, 3};
        vecs[4]  = '{4'b1111, 0};
        vecs[5]  = '{4'b0100, 2};
        vecs[6]  = '{4'b0100, 2};
        vecs[7]  = '{4'b1001, 3};
        vecs[8]  = '{4'b1001, 0};
        vecs[9]  = '{4'b0011, 1};
        vecs[10] = '{4'b0011, 0};
        vecs[11] = '{4'b1010, 1};
        vecs[12] = '{4'b1010, 3};
        vecs[13] = '{4'b0110, 1};

        // Idle with no requests; tx_ready high must be ignored.
        do_reset();
        check("rst_grant_ch", 32'(grant_ch), 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        for (int k = 0; k < 20; k++) begin
            #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_tx_valid", 32'(tx_valid), 32'd0);
            check("idle_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end

        // Table-driven round-robin decisions.
        for (int i = 0; i < 14; i++) begin
            grant_one("rr", vecs[i].mask, vecs[i].ch);
        end

        // All valid continuously: data sequence and spacing.
        do_reset();
        req_valid = 4'b1111;
        for (int unsigned k = 0; k < 5 * Period; k++) begin
            #1;
            check("seq_ready", 32'(req_ready),
                  (k % Period == 0) ? (32'd1 << ((k / Period) % 4)) : 32'd0);
            check("seq_valid", 32'(tx_valid), (k % Period == 1) ? 32'd1 : 32'd0);
            if (k % Period == 1) begin
                check("seq_data", tx_data, 32'hA0 + (k / Period) % 4);
            end
            @(negedge clk);
        end
        req_valid = '0;
        wait_idle();

        // Channel 2 alone: re-granted every Period cycles.
        do_reset();
        req_valid = 4'b0100;
        for (int unsigned k = 0; k < 4 * Period; k++) begin
            #1;
            check("solo_ready", 32'(req_ready), (k % Period == 0) ? 32'h4 : 32'd0);
            if (k % Period == 1) begin
                check("solo_grant", 32'(grant_ch), 32'd2);
            end
            @(negedge clk);
        end
        req_valid = '0;
        wait_idle();

        // Stall: channel 1 held 10 cycles while others request.
        do_reset();
        ch_data[1] = 32'hDEADBEEF;
        tx_ready   = 1'b0;
        req_valid  = 4'b0010;
        #1;
        check("stall_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", tx_data, 32'hDEADBEEF);
            check("stall_no_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        #1;
        check("stall_accept_valid", 32'(tx_valid), 32'd1);
        check("stall_accept_data", tx_data, 32'hDEADBEEF);
        @(negedge clk);
        req_valid = '0;
        wait_idle();
        ch_data[1] = 32'hA1;
        grant_one("post_stall", 4'b1111, 2);

        // Reset mid-SEND discards the held word.
        do_reset();
        ch_data[0] = 32'h11111111;
        tx_ready   = 1'b0;
        req_valid  = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        check("abort_held", tx_data, 32'h11111111);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_tx_data", tx_data, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_grant_ch", 32'(grant_ch), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        ch_data[0] = 32'hA0;
        tx_ready   = 1'b1;
        grant_one("after_abort", 4'b1000, 3);

        // last_grant is 3: channel 0 wins before channel 3.
        grant_one("wrap_a", 4'b1001, 0);
        grant_one("wrap_b", 4'b1001, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
